// File: rtl/mmix_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmix_wb_queue: register-file write-back queue, one regwrite per cycle.     |
// | Optional secondary (special-register) writes under MMIX_WB_SECOND_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmix_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_enable,
  input  logic [7:0]                 in_addr,
  input  logic [63:0]                in_data,
  input  logic                       in_sec_valid,
  input  logic [7:0]                 in_sec_addr,
  input  logic [63:0]                in_sec_data,
  output logic [1:0]                 regw_enable,
  output logic [7:0]                 regw_addr,
  output logic [63:0]                regw_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       idle
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]    en_q   [DEPTH];
  logic [1:0]    en_d   [DEPTH];
  logic [7:0]    addr_q [DEPTH];
  logic [7:0]    addr_d [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [63:0]   data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    regw_enable_q, regw_enable_d;
  logic [7:0]    regw_addr_q, regw_addr_d;
  logic [63:0]   regw_data_q, regw_data_d;
  logic          idle_q, idle_d;
  logic [1:0]    en_n;
  logic          accept, push, pop;

`ifdef MMIX_WB_SECOND_EN
  typedef enum logic [0:0] {ISSUE = 1'b0, SEC = 1'b1} state_t;
  state_t        state_q, state_d;
  logic          sv_q    [DEPTH];
  logic          sv_d    [DEPTH];
  logic [7:0]    saddr_q [DEPTH];
  logic [7:0]    saddr_d [DEPTH];
  logic [63:0]   sdata_q [DEPTH];
  logic [63:0]   sdata_d [DEPTH];
  logic [7:0]    sec_addr_q, sec_addr_d;
  logic [63:0]   sec_data_q, sec_data_d;
`else
  logic          unused_sec;
  assign unused_sec = ^{in_sec_valid, in_sec_addr, in_sec_data};
`endif

  // Depends only on the occupancy register and reset: no same-cycle pop bypass.
  assign in_ready    = (count_q != FULL) && !reset;
  assign count       = count_q;
  assign idle        = idle_q;
  assign regw_enable = regw_enable_q;
  assign regw_addr   = regw_addr_q;
  assign regw_data   = regw_data_q;

  always_comb begin
    en_n          = (in_enable == 2'b11) ? 2'b01 : in_enable;
    accept        = in_valid && in_ready;
    en_d          = en_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    regw_enable_d = 2'b00;
    regw_addr_d   = regw_addr_q;
    regw_data_d   = regw_data_q;
`ifdef MMIX_WB_SECOND_EN
    sv_d          = sv_q;
    saddr_d       = saddr_q;
    sdata_d       = sdata_q;
    sec_addr_d    = sec_addr_q;
    sec_data_d    = sec_data_q;
    state_d       = state_q;
    push          = accept && ((en_n != 2'b00) || in_sec_valid);
    pop           = (state_q == ISSUE) && (count_q != '0);
`else
    push          = accept && (en_n != 2'b00);
    pop           = (count_q != '0);
`endif

    if (push) begin
      en_d[wr_ptr_q]    = en_n;
      addr_d[wr_ptr_q]  = in_addr;
      data_d[wr_ptr_q]  = in_data;
`ifdef MMIX_WB_SECOND_EN
      sv_d[wr_ptr_q]    = in_sec_valid;
      saddr_d[wr_ptr_q] = in_sec_addr;
      sdata_d[wr_ptr_q] = in_sec_data;
`endif
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      regw_enable_d = en_q[rd_ptr_q];
      regw_addr_d   = addr_q[rd_ptr_q];
      regw_data_d   = data_q[rd_ptr_q];
      rd_ptr_d      = rd_ptr_q + 1'b1;
`ifdef MMIX_WB_SECOND_EN
      // Latch the secondary now: the slot may be refilled before SEC issues it.
      if (sv_q[rd_ptr_q]) begin
        sec_addr_d = saddr_q[rd_ptr_q];
        sec_data_d = sdata_q[rd_ptr_q];
        state_d    = SEC;
      end
`endif
    end

`ifdef MMIX_WB_SECOND_EN
    if (state_q == SEC) begin
      regw_enable_d = 2'b01;
      regw_addr_d   = sec_addr_q;
      regw_data_d   = sec_data_q;
      state_d       = ISSUE;
    end
`endif

    count_d = count_q + CW'(push) - CW'(pop);
`ifdef MMIX_WB_SECOND_EN
    idle_d  = (count_d == '0) && (regw_enable_d == 2'b00) && (state_d == ISSUE);
`else
    idle_d  = (count_d == '0) && (regw_enable_d == 2'b00);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        en_q[i]    <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
`ifdef MMIX_WB_SECOND_EN
        sv_q[i]    <= 1'b0;
        saddr_q[i] <= '0;
        sdata_q[i] <= '0;
`endif
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      regw_enable_q <= 2'b00;
      regw_addr_q   <= '0;
      regw_data_q   <= '0;
      idle_q        <= 1'b1;
`ifdef MMIX_WB_SECOND_EN
      sec_addr_q    <= '0;
      sec_data_q    <= '0;
      state_q       <= ISSUE;
`endif
    end else begin
      en_q          <= en_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      regw_enable_q <= regw_enable_d;
      regw_addr_q   <= regw_addr_d;
      regw_data_q   <= regw_data_d;
      idle_q        <= idle_d;
`ifdef MMIX_WB_SECOND_EN
      sv_q          <= sv_d;
      saddr_q       <= saddr_d;
      sdata_q       <= sdata_d;
      sec_addr_q    <= sec_addr_d;
      sec_data_q    <= sec_data_d;
      state_q       <= state_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmix_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmix_wb_queue: directed vector table plus multi-cycle sequences.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mmix_wb_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_enable = 2'b00;
  logic [7:0]  in_addr = 8'h00;
  logic [63:0] in_data = 64'h0;
  logic        in_sec_valid = 1'b0;
  logic [7:0]  in_sec_addr = 8'h00;
  logic [63:0] in_sec_data = 64'h0;
  logic [1:0]  regw_enable;
  logic [7:0]  regw_addr;
  logic [63:0] regw_data;
  logic [2:0]  count;
  logic        idle;

  int checks = 0;
  int failures = 0;

  mmix_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_enable(in_enable), .in_addr(in_addr), .in_data(in_data),
    .in_sec_valid(in_sec_valid), .in_sec_addr(in_sec_addr), .in_sec_data(in_sec_data),
    .regw_enable(regw_enable), .regw_addr(regw_addr), .regw_data(regw_data),
    .count(count), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  en;
    logic [7:0]  a;
    logic [63:0] d;
    logic [1:0]  xen;
    logic [7:0]  xa;
    logic [63:0] xd;
    logic [2:0]  xcnt;
    logic        xidle;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] en, input logic [7:0] a,
                       input logic [63:0] d, input logic sv, input logic [7:0] sa,
                       input logic [63:0] sd);
    in_valid = v; in_enable = en; in_addr = a; in_data = d;
    in_sec_valid = sv; in_sec_addr = sa; in_sec_data = sd;
  endtask

`ifdef MMIX_WB_SECOND_EN
  logic [73:0] expq[$];
  int          max_cnt;

  task automatic collect();
    if (count > max_cnt) max_cnt = count;
    if (regw_enable != 2'b00) begin
      if (expq.size() == 0) begin
        chk("unexpected_write", {regw_enable, regw_addr, regw_data}, 74'h0);
      end else begin
        chk("fill_order", {regw_enable, regw_addr, regw_data}, expq.pop_front());
      end
    end
  endtask
`endif

  initial begin
    // inputs, then expected {enable, addr, data, count, idle} after the edge
    tbl[0] = '{1'b1, 2'b01, 8'h20, 64'h1234, 2'b00, 8'h00, 64'h0,    3'd1, 1'b0};
    tbl[1] = '{1'b0, 2'b00, 8'h00, 64'h0,    2'b01, 8'h20, 64'h1234, 3'd0, 1'b0};
    tbl[2] = '{1'b0, 2'b00, 8'h00, 64'h0,    2'b00, 8'h20, 64'h1234, 3'd0, 1'b1};
    tbl[3] = '{1'b1, 2'b11, 8'h33, 64'hAA,   2'b00, 8'h20, 64'h1234, 3'd1, 1'b0};
    tbl[4] = '{1'b1, 2'b10, 8'h44, 64'hBB,   2'b01, 8'h33, 64'hAA,   3'd1, 1'b0};
    tbl[5] = '{1'b1, 2'b00, 8'h55, 64'hCC,   2'b10, 8'h44, 64'hBB,   3'd0, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 8'h00, 64'h0,    2'b00, 8'h44, 64'hBB,   3'd0, 1'b1};

    #2;
    chk("reset_in_ready", in_ready, 1'b0);
    tick();
    chk("reset_enable", regw_enable, 2'b00);
    chk("reset_addr", regw_addr, 8'h00);
    chk("reset_data", regw_data, 64'h0);
    chk("reset_count", count, 3'd0);
    chk("reset_idle", idle, 1'b1);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].en, tbl[i].a, tbl[i].d, 1'b0, 8'h00, 64'h0);
      tick();
      chk($sformatf("tbl%0d_enable", i), regw_enable, tbl[i].xen);
      chk($sformatf("tbl%0d_addr", i), regw_addr, tbl[i].xa);
      chk($sformatf("tbl%0d_data", i), regw_data, tbl[i].xd);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].xcnt);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].xidle);
      chk($sformatf("tbl%0d_ready", i), in_ready, 1'b1);
    end

    // Back-to-back singles: pointers wrap twice, occupancy stays at one.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("wrap%0d_ready", i), in_ready, 1'b1);
      drive(1'b1, 2'b01, 8'(i), 64'(i + 100), 1'b0, 8'h00, 64'h0);
      tick();
      chk($sformatf("wrap%0d_count", i), count, 3'd1);
      if (i > 0) begin
        chk($sformatf("wrap%0d_enable", i), regw_enable, 2'b01);
        chk($sformatf("wrap%0d_addr", i), regw_addr, 8'(i - 1));
        chk($sformatf("wrap%0d_data", i), regw_data, 64'(i + 99));
      end
    end
    drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("wrap_last_addr", regw_addr, 8'd8);
    chk("wrap_last_enable", regw_enable, 2'b01);
    chk("wrap_last_count", count, 3'd0);
    tick();
    chk("wrap_idle", idle, 1'b1);

`ifdef MMIX_WB_SECOND_EN
    // Dual result: primary then secondary on consecutive cycles.
    drive(1'b1, 2'b10, 8'h05, 64'hA0A0, 1'b1, 8'h03, 64'hB0B0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
    chk("dual_count", count, 3'd1);
    tick();
    chk("dual_pri", {regw_enable, regw_addr, regw_data}, {2'b10, 8'h05, 64'hA0A0});
    tick();
    chk("dual_sec", {regw_enable, regw_addr, regw_data}, {2'b01, 8'h03, 64'hB0B0});
    chk("dual_sec_idle", idle, 1'b0);
    tick();
    chk("dual_done_enable", regw_enable, 2'b00);
    chk("dual_done_idle", idle, 1'b1);

    // Secondary-only entry.
    drive(1'b1, 2'b00, 8'h07, 64'h7, 1'b1, 8'h06, 64'h66);
    tick();
    drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
    chk("seconly_count", count, 3'd1);
    tick();
    chk("seconly_pri_enable", regw_enable, 2'b00);
    tick();
    chk("seconly_sec", {regw_enable, regw_addr, regw_data}, {2'b01, 8'h06, 64'h66});
    tick();

    // Sustained dual input fills the queue; all writes drain in order.
    begin
      int n = 0;
      bit seen_full = 0;
      max_cnt = 0;
      for (int cyc = 0; cyc < 40 && !seen_full; cyc++) begin
        if (in_ready) begin
          drive(1'b1, 2'b10, 8'h80 + 8'(n), 64'(n), 1'b1, 8'h03, 64'hF000 + 64'(n));
          expq.push_back({2'b10, 8'h80 + 8'(n), 64'(n)});
          expq.push_back({2'b01, 8'h03, 64'hF000 + 64'(n)});
          n++;
        end else begin
          drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
          seen_full = 1;
        end
        tick();
        collect();
      end
      drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
      for (int cyc = 0; cyc < 30; cyc++) begin
        tick();
        collect();
      end
      chk("fill_seen_full", seen_full, 1'b1);
      chk("fill_max_count", max_cnt, 4);
      chk("fill_all_drained", expq.size(), 0);
      chk("fill_end_count", count, 3'd0);
    end

    // Reset while the secondary write is pending.
    drive(1'b1, 2'b01, 8'h09, 64'h99, 1'b1, 8'h03, 64'h33);
    tick();
    drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
    tick();
    chk("rsec_pri", {regw_enable, regw_addr}, {2'b01, 8'h09});
    reset = 1'b1;
    #1;
    chk("rsec_enable", regw_enable, 2'b00);
    chk("rsec_count", count, 3'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rsec_no_sec", regw_enable, 2'b00);
    chk("rsec_idle", idle, 1'b1);
`endif

    // Asynchronous reset with writes outstanding.
    drive(1'b1, 2'b01, 8'h60, 64'h60, 1'b0, 8'h00, 64'h0);
    tick();
    drive(1'b1, 2'b01, 8'h61, 64'h61, 1'b0, 8'h00, 64'h0);
    tick();
    drive(1'b0, 2'b00, 8'h00, 64'h0, 1'b0, 8'h00, 64'h0);
    chk("mid_pre_addr", regw_addr, 8'h60);
    chk("mid_pre_count", count, 3'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_enable", regw_enable, 2'b00);
    chk("mid_addr", regw_addr, 8'h00);
    chk("mid_count", count, 3'd0);
    chk("mid_idle", idle, 1'b1);
    chk("mid_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_after_enable", regw_enable, 2'b00);
    chk("mid_after_count", count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
